// File: rtl/rat_reduce_if.sv
// Handshake bundle for rat_reduce: unreduced num/den in, reduced num/den/err out.
interface rat_reduce_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_num;
   logic [WIDTH-1:0] in_den;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_num;
   logic [WIDTH-1:0] out_den;
   logic             out_err;

   modport master (
      output in_valid, in_num, in_den, out_ready,
      input  in_ready, out_valid, out_num, out_den, out_err
   );

   modport slave (
      input  in_valid, in_num, in_den, out_ready,
      output in_ready, out_valid, out_num, out_den, out_err
   );
endinterface

// File: rtl/rat_reduce.sv
// Rational normaliser: Stein GCD, then two restoring dividers (n0/g, d0/g).
// Optional RAT_REDUCE_FASTPATH_EN skips the divide when g==1.
module rat_reduce #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   rat_reduce_if.slave bus
);
   localparam int KW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] n0, d0, a, b, g;
   logic [WIDTH-1:0] rn, rd, qn, qd;
   logic [KW-1:0]    k, cnt;
   logic [WIDTH-1:0] out_num, out_den;
   logic             out_err;

   logic             gcd_done;
   logic [WIDTH-1:0] g_calc;
   logic [WIDTH:0]   rn_sh, rd_sh;
   logic             ge_n, ge_d;
   logic [WIDTH-1:0] rn_nxt, rd_nxt;
   logic             div_last;
   logic             fast_hit;

   assign gcd_done = (a == b) || (a == '0) || (b == '0);
   assign g_calc   = ((a == '0) || (b == '0)) ? ((a | b) << k) : (a << k);

   // a/b are reused as the dividend shift registers during DIV
   assign rn_sh  = {rn, a[WIDTH-1]};
   assign rd_sh  = {rd, b[WIDTH-1]};
   assign ge_n   = rn_sh >= {1'b0, g};
   assign ge_d   = rd_sh >= {1'b0, g};
   assign rn_nxt = ge_n ? WIDTH'(rn_sh - {1'b0, g}) : rn_sh[WIDTH-1:0];
   assign rd_nxt = ge_d ? WIDTH'(rd_sh - {1'b0, g}) : rd_sh[WIDTH-1:0];
   assign div_last = (cnt == KW'(WIDTH - 1));

`ifdef RAT_REDUCE_FASTPATH_EN
   assign fast_hit = (g_calc == WIDTH'(1));
`else
   assign fast_hit = 1'b0;
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_num   = out_num;
   assign bus.out_den   = out_den;
   assign bus.out_err   = out_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) begin
            if (bus.in_den == '0 || bus.in_num == '0) state_nxt = DONE;
            else                                       state_nxt = GCD;
         end
         GCD:  if (gcd_done) state_nxt = fast_hit ? DONE : DIV;
         DIV:  if (div_last) state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n0 <= '0; d0 <= '0; a <= '0; b <= '0; g <= '0;
         rn <= '0; rd <= '0; qn <= '0; qd <= '0;
         k <= '0; cnt <= '0;
         out_num <= '0; out_den <= '0; out_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               n0 <= bus.in_num;
               d0 <= bus.in_den;
               a  <= bus.in_num;
               b  <= bus.in_den;
               k  <= '0;
               if (bus.in_den == '0) begin
                  out_num <= bus.in_num;
                  out_den <= '0;
                  out_err <= 1'b1;
               end else if (bus.in_num == '0) begin
                  out_num <= '0;
                  out_den <= WIDTH'(1);
                  out_err <= 1'b0;
               end
            end
            GCD: if (gcd_done) begin
               g   <= g_calc;
               a   <= n0;
               b   <= d0;
               rn  <= '0;
               rd  <= '0;
               cnt <= '0;
               if (fast_hit) begin
                  out_num <= n0;
                  out_den <= d0;
                  out_err <= 1'b0;
               end
            end else begin
               case ({a[0], b[0]})
                  2'b00: begin a <= a >> 1; b <= b >> 1; k <= k + KW'(1); end
                  2'b01: a <= a >> 1;
                  2'b10: b <= b >> 1;
                  default: begin
                     if (a > b) a <= (a - b) >> 1;
                     else       b <= (b - a) >> 1;
                  end
               endcase
            end
            DIV: begin
               a   <= a << 1;
               b   <= b << 1;
               rn  <= rn_nxt;
               rd  <= rd_nxt;
               qn  <= {qn[WIDTH-2:0], ge_n};
               qd  <= {qd[WIDTH-2:0], ge_d};
               cnt <= cnt + KW'(1);
               if (div_last) begin
                  out_num <= {qn[WIDTH-2:0], ge_n};
                  out_den <= {qd[WIDTH-2:0], ge_d};
                  out_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/rat_reduce.md
# rat_reduce

Sequential rational normaliser: accepts an unsigned numerator/denominator pair and returns the fraction reduced to lowest terms. It uses a binary (Stein) GCD followed by a dual restoring divide. It sits downstream of the combinational rational arithmetic units (`add` and its siblings), which emit unreduced cross-product results. It is the consumer end of their num/den result interface, and it re-presents results on a valid/ready handshake.

## Interface
- WIDTH, 32, bit width of every numerator/denominator port
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input pair is presented
- in_ready  output  1  block can accept a pair (high only in IDLE)
- in_num  input  WIDTH  unsigned numerator
- in_den  input  WIDTH  unsigned denominator
- out_valid  output  1  reduced result is presented
- out_ready  input  1  downstream accepts result
- out_num  output  WIDTH  reduced numerator
- out_den  output  WIDTH  reduced denominator
- out_err  output  1  input denominator was zero

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- States: IDLE, GCD, DIV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_num/in_den into n0/d0, and into working regs a/b. Set k=0. Next state:
  - in_den==0: go to DONE with out_num=in_num, out_den=0, out_err=1.
  - in_num==0 (den≠0): go to DONE with out_num=0, out_den=1, out_err=0.
  - otherwise: go to GCD.
- GCD performs one Stein step per cycle:
  - both a and b even: a>>=1, b>>=1, k++.
  - only a even: a>>=1.
  - only b even: b>>=1.
  - both odd: larger := (larger−smaller)>>1.
  - Exit when a==b (or either reaches 0). Then g=(a|b)<<k if one is 0, else a<<k. Go to DIV.
  - Bound: ≤2·WIDTH cycles.
- DIV: two parallel restoring dividers compute n0/g and d0/g, one quotient bit per cycle, exactly WIDTH cycles. Remainders are zero by construction and are discarded. Then go to DONE.
- DONE: out_valid=1. out_num/out_den/out_err hold stable until out_ready. On out_valid&&out_ready, go to IDLE. There is no same-cycle bypass: in_ready rises on the next cycle.
- Arithmetic is unsigned throughout. k needs clog2(WIDTH)+1 bits. The g register is WIDTH bits and never overflows, since g ≤ min(n0,d0).
- in_num/in_den are ignored outside IDLE.

## Timing
- Reset (async assert, any state, including mid-GCD/DIV): state=IDLE, in_ready=1, out_valid=0, out_num=0, out_den=0, out_err=0. Any in-flight pair is discarded, with no partial output.
- Reset release is synchronous to clk. The first accept is possible on the first edge with rst_n high.
- Special cases (den==0 or num==0): out_valid is high 1 cycle after the accept edge.
- General case: out_valid is high G+WIDTH+1 cycles after the accept edge, where G is the number of GCD steps (1 ≤ G ≤ 2·WIDTH).
- Throughput: one pair in flight. Back-to-back minimum period is latency+1 cycles.
- Output regs change only on the edge entering DONE, or on reset.

## Configuration
- RAT_REDUCE_FASTPATH_EN:
  - Defined: on GCD exit with g==1, skip DIV, load out_num=n0 and out_den=d0, and enter DONE directly. Latency is G+1.
  - Undefined: DIV always runs the full WIDTH cycles regardless of g. Latency is always G+WIDTH+1.
  - Results are bit-identical in both builds.

## Test plan
- 12/18, out_ready=1 -> out_num=2, out_den=3, out_err=0. Latency is G+WIDTH+1.
- 7/13 -> 7/13:
  - with RAT_REDUCE_FASTPATH_EN: out_valid at G+1 cycles.
  - without: out_valid at G+33 cycles.
- 0/7 -> 0/1; 5/0 -> 5/0 with out_err=1. Both with out_valid exactly 1 cycle after accept.
- 4294967294/2147483647 (WIDTH=32) -> 2/1. Also check that G ≤ 64.
- 100/75 with out_ready held low 10 cycles after out_valid:
  - outputs stay 4/3 and stable.
  - in_ready stays 0 and a new in_valid pair is ignored.
  - in_ready rises the cycle after out_ready is taken.
- Assert rst_n low during DIV of 60/84, then release:
  - all outputs are 0 immediately, with in_ready=1.
  - a following 9/6 returns 3/2 with no trace of the aborted pair.
